// File: rtl/fifo_rd_stream_adapter_if.sv
// rtl/fifo_rd_stream_adapter_if.sv - FIFO read side plus valid/ready stream bundle for the read adapter
interface fifo_rd_stream_adapter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_pop;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [CNT_W-1:0] xfer_count;
    logic [1:0]       occupancy;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  m_ready,
        output fifo_pop,
        output m_valid,
        output m_data,
        output xfer_count,
        output occupancy
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output m_ready,
        input  fifo_pop,
        input  m_valid,
        input  m_data,
        input  xfer_count,
        input  occupancy
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - pops a registered-read FIFO into a 2-entry skid buffer feeding a valid/ready stream
module fifo_rd_stream_adapter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_rd_stream_adapter_if.master bus
);
    logic [WIDTH-1:0] buf_mem [2];
    logic             head;
    logic             tail;
    logic             inflight;
    logic [1:0]       count;
    logic [CNT_W-1:0] xfer_cnt;
    logic             deq;
    logic [2:0]       level;

    // level is the occupancy after this edge, counting the word already requested from the FIFO
    always_comb begin
        deq   = (count != 2'd0) && bus.m_ready;
        level = 3'(count) + 3'(inflight) - 3'(deq);
    end

    assign bus.fifo_pop   = !rst && !bus.fifo_empty && (level < 3'd2);
    assign bus.m_valid    = (count != 2'd0);
    assign bus.m_data     = buf_mem[head];
    assign bus.occupancy  = count;
    assign bus.xfer_count = xfer_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            head       <= 1'b0;
            tail       <= 1'b0;
            inflight   <= 1'b0;
            count      <= 2'd0;
            xfer_cnt   <= '0;
        end else begin
            inflight <= bus.fifo_pop;
            if (inflight) begin
                buf_mem[tail] <= bus.fifo_rd_data;
                tail          <= ~tail;
            end
            if (deq) begin
                head     <= ~head;
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            count <= level[1:0];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (3'(count) + 3'(inflight)) <= 3'd2);
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb/tb_fifo_rd_stream_adapter.sv - randomized scoreboard bench for fifo_rd_stream_adapter with a behavioural FIFO
module tb_fifo_rd_stream_adapter;
    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_adapter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    fifo_rd_stream_adapter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO: registered read data one cycle after pop
    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] pend_q [$];
    logic             fifo_flush = 1'b1;

    always @(posedge clk) begin
        if (fifo_flush) begin
            fifo_q.delete();
            pend_q.delete();
            bus.fifo_empty <= 1'b1;
        end else begin
            if (bus.fifo_pop && fifo_q.size() != 0)
                bus.fifo_rd_data <= fifo_q.pop_front();
            while (pend_q.size() != 0)
                fifo_q.push_back(pend_q.pop_front());
            bus.fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Reference model: words pushed must come out in order; occupancy is words landed minus words taken
    logic [WIDTH-1:0] sb_q [$];
    logic             mon_en = 1'b0;
    int               landed, accepted, rx_count;
    int               pop_d1, pop_d2, acc_d1;
    logic             hold_prev;
    logic [WIDTH-1:0] prev_data;
    logic [WIDTH-1:0] exp_w;
    logic             acc_now;

    task automatic mon_reset();
        landed = 0; accepted = 0; rx_count = 0;
        pop_d1 = 0; pop_d2 = 0; acc_d1 = 0;
        hold_prev = 1'b0; prev_data = '0;
        sb_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            landed   += pop_d2;
            accepted += acc_d1;
            checks++;
            if ($isunknown(bus.occupancy) || int'(bus.occupancy) != landed - accepted) begin
                errors++;
                $display("FAIL occupancy: got %0d expected %0d at %0t", bus.occupancy, landed - accepted, $time);
            end
            checks++;
            if (bus.m_valid !== (landed != accepted)) begin
                errors++;
                $display("FAIL m_valid: got %b expected %b at %0t", bus.m_valid, landed != accepted, $time);
            end
            checks++;
            if (bus.xfer_count !== CNT_W'(accepted)) begin
                errors++;
                $display("FAIL xfer_count: got %0d expected %0d at %0t", bus.xfer_count, CNT_W'(accepted), $time);
            end
            checks++;
            if (int'(bus.occupancy) + pop_d1 > 2) begin
                errors++;
                $display("FAIL invariant: occupancy %0d plus inflight %0d exceeds 2 at %0t", bus.occupancy, pop_d1, $time);
            end
            if (hold_prev) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b data=%0d expected valid=1 data=%0d", bus.m_valid, bus.m_data, prev_data);
                end
            end
            acc_now = bus.m_valid && bus.m_ready;
            if (acc_now) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: got extra word %0d expected none", bus.m_data);
                end else begin
                    exp_w = sb_q.pop_front();
                    if (bus.m_data !== exp_w) begin
                        errors++;
                        $display("FAIL order: got %0d expected %0d at %0t", bus.m_data, exp_w, $time);
                    end
                end
                rx_count++;
            end
            hold_prev = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            pop_d2 = pop_d1;
            pop_d1 = int'(bus.fifo_pop);
            acc_d1 = int'(acc_now);
        end
    end

    task automatic push_word(input logic [WIDTH-1:0] w);
        pend_q.push_back(w);
        sb_q.push_back(w);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b0;
        mon_reset();
        fifo_flush = 1'b1;
        @(posedge clk); #1;
        fifo_flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.xfer_count !== '0 || bus.m_data !== '0 || bus.fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b occ=%0d cnt=%0d data=%0d pop=%b expected all zero",
                     bus.m_valid, bus.occupancy, bus.xfer_count, bus.m_data, bus.fifo_pop);
        end
        fifo_flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(WIDTH'(i + 2));
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        checks++;
        if (bus.fifo_pop !== 1'b0 || bus.m_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.xfer_count !== '0 || bus.m_data !== '0) begin
            errors++;
            $display("FAIL async_reset: got pop=%b valid=%b occ=%0d cnt=%0d data=%0d expected all zero (fifo_empty=%b)",
                     bus.fifo_pop, bus.m_valid, bus.occupancy, bus.xfer_count, bus.m_data, bus.fifo_empty);
        end
        do_reset();
    endtask

    task automatic test_latency();
        logic [WIDTH-1:0] exp_d [3];
        exp_d[0] = 4'd3; exp_d[1] = 4'd5; exp_d[2] = 4'd7;
        do_reset();
        bus.m_ready = 1'b1;
        push_word(4'd3); push_word(4'd5); push_word(4'd7);
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus.fifo_pop !== (c < 3)) begin
                errors++;
                $display("FAIL latency_pop: cycle %0d got %b expected %b", c, bus.fifo_pop, c < 3);
            end
            checks++;
            if (bus.m_valid !== (c >= 2 && c <= 4)) begin
                errors++;
                $display("FAIL latency_valid: cycle %0d got %b expected %b", c, bus.m_valid, c >= 2 && c <= 4);
            end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (bus.m_data !== exp_d[c-2]) begin
                    errors++;
                    $display("FAIL latency_data: cycle %0d got %0d expected %0d", c, bus.m_data, exp_d[c-2]);
                end
            end
        end
        checks++;
        if (bus.xfer_count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL latency_count: got %0d expected 3", bus.xfer_count);
        end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        logic [WIDTH-1:0] got [$];
        do_reset();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(WIDTH'(i));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pops += int'(bus.fifo_pop);
        end
        checks++;
        if (pops != 2 || bus.occupancy !== 2'd2 || bus.m_data !== 4'd1) begin
            errors++;
            $display("FAIL backpressure_hold: got pops=%0d occ=%0d data=%0d expected pops=2 occ=2 data=1", pops, bus.occupancy, bus.m_data);
        end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            @(negedge clk);
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL backpressure_drain: got %0d words expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== WIDTH'(i + 1)) begin
                    errors++;
                    $display("FAIL backpressure_order: word %0d got %0d expected %0d", i, got[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_drain_empty();
        int pops = 0;
        int valids = 0;
        logic [WIDTH-1:0] seen = '0;
        do_reset();
        bus.m_ready = 1'b1;
        push_word(4'd9);
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pops += int'(bus.fifo_pop);
            if (bus.m_valid) begin
                valids++;
                seen = bus.m_data;
            end
        end
        checks++;
        if (pops != 1 || valids != 1 || seen !== 4'd9) begin
            errors++;
            $display("FAIL drain_empty: got pops=%0d valid_cycles=%0d data=%0d expected 1 1 9", pops, valids, seen);
        end
        checks++;
        if (bus.m_valid !== 1'b0 || bus.fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: got valid=%b pop=%b expected 0 0", bus.m_valid, bus.fifo_pop);
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        int cyc = 0;
        do_reset();
        while (rx_count < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                push_word(WIDTH'($urandom));
                pushed++;
            end
            bus.m_ready = $urandom_range(0, 1) == 1;
            cyc++;
        end
        @(negedge clk);
        checks++;
        if (rx_count != 1000 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL random_stream: got %0d words with %0d left over, expected 1000 and 0", rx_count, sb_q.size());
        end
    endtask

    task automatic test_counter_wrap();
        int cyc = 0;
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_word(WIDTH'(i));
            @(posedge clk); #1;
        end
        while (rx_count < 17 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.xfer_count !== CNT_W'(1) || bus.occupancy !== 2'd0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL counter_wrap: got cnt=%0d occ=%0d valid=%b expected 1 0 0", bus.xfer_count, bus.occupancy, bus.m_valid);
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        mon_reset();
        test_reset();
        test_latency();
        test_backpressure();
        test_drain_empty();
        test_random();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
